// File: rtl/gb_alu_sub16_seq.sv
// gb_alu_sub16_seq: sequential 16-bit subtractor (SUB/SBC style).
// A nibble-serial datapath computes i_a - i_b - i_c over four RUN cycles,
// LSB nibble first. It captures the half-borrows from bit 3 (h8) and
// bit 11 (h), and the borrow from bit 15 (c).
// The result registers only change on the RUN->DONE edge.
// Handshake: i_start is a request that is only taken in IDLE or DONE;
// o_busy is high for the four RUN cycles; o_done is a one-cycle pulse
// in DONE, and o_d/o_c/o_h/o_h8/o_z/o_n are valid from that cycle until
// the next o_done.
module gb_alu_sub16_seq (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_c,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_d,
  output logic        o_c,
  output logic        o_h,
  output logic        o_h8,
  output logic        o_z,
  output logic        o_n,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  cnt;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        brw;
  logic [15:0] d_w;
  logic        h8_w;
  logic        h_w;

  logic [3:0]  a_nib;
  logic [3:0]  b_nib;
  logic [4:0]  sub5;
  logic        nib_brw;
  logic        take_start;
  logic        last_nib;

  // Start is only honoured outside RUN; the last nibble ends the operation.
  assign take_start = i_start && (state != RUN);
  assign last_nib   = (state == RUN) && (cnt == 2'd3);

  // One nibble of the subtraction; bit 4 of the 5-bit result is the borrow.
  always_comb begin
    a_nib   = a_q[{cnt, 2'b00} +: 4];
    b_nib   = b_q[{cnt, 2'b00} +: 4];
    sub5    = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0000, brw};
    nib_brw = sub5[4];
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = i_start ? RUN : IDLE;
      RUN:  state_nxt = (cnt == 2'd3) ? DONE : RUN;
      DONE: state_nxt = i_start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Working registers: operand latch on start, nibble ripple during RUN.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt  <= 2'd0;
      a_q  <= 16'h0000;
      b_q  <= 16'h0000;
      brw  <= 1'b0;
      d_w  <= 16'h0000;
      h8_w <= 1'b0;
      h_w  <= 1'b0;
    end else if (take_start) begin
      cnt  <= 2'd0;
      a_q  <= i_a;
      b_q  <= i_b;
      brw  <= i_c;
      d_w  <= 16'h0000;
      h8_w <= 1'b0;
      h_w  <= 1'b0;
    end else if (state == RUN) begin
      cnt                   <= cnt + 2'd1;
      brw                   <= nib_brw;
      d_w[{cnt, 2'b00} +: 4] <= sub5[3:0];
      if (cnt == 2'd0) h8_w <= nib_brw;
      if (cnt == 2'd2) h_w  <= nib_brw;
    end
  end

  // Result registers: loaded once per operation on the RUN->DONE edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_d  <= 16'h0000;
      o_c  <= 1'b0;
      o_h  <= 1'b0;
      o_h8 <= 1'b0;
      o_z  <= 1'b1;
      o_n  <= 1'b0;
    end else if (last_nib) begin
      o_d  <= {sub5[3:0], d_w[11:0]};
      o_c  <= nib_brw;
      o_h  <= h_w;
      o_h8 <= h8_w;
      o_z  <= ({sub5[3:0], d_w[11:0]} == 16'h0000);
      o_n  <= 1'b1;
    end
  end

  assign o_busy  = (state == RUN);
  assign o_done  = (state == DONE);
  assign o_state = state;

endmodule

// File: tb/tb_gb_alu_sub16_seq.sv
// Testbench for gb_alu_sub16_seq: directed vectors, start-ignore,
// back-to-back, reset abort, plus random operations checked through an
// expected-result queue.
module tb_gb_alu_sub16_seq;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic [15:0] i_a;
  logic [15:0] i_b;
  logic        i_c;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_d;
  logic        o_c;
  logic        o_h;
  logic        o_h8;
  logic        o_z;
  logic        o_n;
  logic [1:0]  o_state;

  // Expected results packed as {d[15:0], c, h, h8, z}.
  logic [19:0] exp_q[$];
  logic [19:0] last_exp;
  int          n_vec;
  int          n_err;

  gb_alu_sub16_seq dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_c     (i_c),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_d     (o_d),
    .o_c     (o_c),
    .o_h     (o_h),
    .o_h8    (o_h8),
    .o_z     (o_z),
    .o_n     (o_n),
    .o_state (o_state)
  );

  // ---------------- clock / reset ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance one cycle; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic c);
    logic [16:0] full;
    logic [12:0] low12;
    logic [4:0]  low4;
    full  = {1'b0, a} - {1'b0, b} - {16'h0000, c};
    low12 = {1'b0, a[11:0]} - {1'b0, b[11:0]} - {12'h000, c};
    low4  = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'h0, c};
    return {full[15:0], full[16], low12[12], low4[4], (full[15:0] == 16'h0000)};
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] res_now();
    return {o_d, o_c, o_h, o_h8, o_z};
  endfunction

  // ---------------- driver ----------------
  // Called in the cycle where start is driven ("cycle 0"). Returns in
  // cycle 5 (the DONE cycle) after checking the popped result.
  // inject_ignored drives a second start with other operands in cycle 2.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input bit inject_ignored, input string tag);
    logic [19:0] exp;
    i_start = 1'b1;
    i_a     = a;
    i_b     = b;
    i_c     = c;
    exp_q.push_back(model(a, b, c));
    step();
    // Operands may wander after the start cycle.
    i_start = 1'b0;
    i_a     = 16'($urandom_range(0, 65535));
    i_b     = 16'($urandom_range(0, 65535));
    i_c     = 1'($urandom_range(0, 1));
    for (int k = 1; k <= 4; k++) begin
      chk({tag, "_busy"}, {18'd0, o_busy, o_done}, 20'b10);
      if (k == 2 && inject_ignored) begin
        i_start = 1'b1;
        i_a     = 16'hABCD;
        i_b     = 16'h1111;
        i_c     = 1'b1;
      end else begin
        i_start = 1'b0;
      end
      step();
    end
    chk({tag, "_done"}, {16'd0, o_state, o_busy, o_done}, {16'd0, 2'd2, 1'b0, 1'b1});
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      exp = exp_q.pop_front();
      chk({tag, "_res"}, res_now(), exp);
      chk({tag, "_n"}, {19'd0, o_n}, 20'd1);
      last_exp = exp;
    end
  endtask

  // Idle for n cycles after DONE, checking that results hold.
  task automatic idle_hold(input int n, input string tag);
    i_start = 1'b0;
    for (int k = 0; k < n; k++) begin
      step();
      chk({tag, "_idle"}, {16'd0, o_state, o_busy, o_done}, 20'd0);
      chk({tag, "_hold"}, res_now(), last_exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec   = 0;
    n_err   = 0;
    i_rst   = 1'b1;
    i_start = 1'b1;
    i_a     = 16'h1234;
    i_b     = 16'h0001;
    i_c     = 1'b0;
    last_exp = 20'd0;

    // Reset state, with start held high (reset wins).
    step();
    step();
    chk("rst_state", {2'd0, o_state, o_busy, o_done, o_n, o_c, o_h, o_h8, o_z, 9'd0},
        {2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'd0});
    chk("rst_d", {4'd0, o_d}, 20'd0);

    // First start in the first cycle with reset low; borrow ripple case.
    i_rst = 1'b0;
    run_op(16'h1000, 16'h0001, 1'b0, 1'b0, "ripple");
    chk("ripple_exact", res_now(), {16'h0FFF, 1'b0, 1'b1, 1'b1, 1'b0});
    idle_hold(2, "ripple");

    run_op(16'h1234, 16'h1234, 1'b0, 1'b0, "zero");
    chk("zero_exact", res_now(), {16'h0000, 1'b0, 1'b0, 1'b0, 1'b1});
    idle_hold(1, "zero");

    run_op(16'h0000, 16'h0000, 1'b1, 1'b0, "wrap");
    chk("wrap_exact", res_now(), {16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0});
    idle_hold(1, "wrap");

    run_op(16'h8000, 16'h7FFF, 1'b0, 1'b0, "mid");
    chk("mid_exact", res_now(), {16'h0001, 1'b0, 1'b1, 1'b1, 1'b0});
    idle_hold(1, "mid");

    // Start ignored during RUN, then back-to-back start in DONE.
    run_op(16'h0005, 16'h0003, 1'b0, 1'b1, "ign");
    chk("ign_exact", {4'd0, o_d}, {4'd0, 16'h0002});
    run_op(16'h0100, 16'h0200, 1'b0, 1'b0, "b2b");
    chk("b2b_exact", res_now(), {16'hFF00, 1'b1, 1'b1, 1'b0, 1'b0});
    idle_hold(1, "b2b");

    // Reset mid-operation: start in cycle 0, reset in cycle 2.
    i_start = 1'b1;
    i_a     = 16'h4321;
    i_b     = 16'h0123;
    i_c     = 1'b0;
    step();
    i_start = 1'b0;
    step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    for (int k = 3; k <= 6; k++) begin
      chk("abort_ctl", {16'd0, o_state, o_busy, o_done}, 20'd0);
      chk("abort_res", {o_d, o_z, o_n, o_c, o_h}, {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0});
      step();
    end

    // Random operations, every other one back-to-back.
    for (int n = 0; n < 24; n++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rc;
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      rc = 1'($urandom_range(0, 1));
      if (n % 6 == 0) rb = ra;
      run_op(ra, rb, rc, (n % 5 == 1), "rand");
      if (n % 2 == 1) idle_hold(1, "rand");
    end

    chk("queue_empty", 20'(exp_q.size()), 20'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
